// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, widths and pattern encodings for the pattern
// source and any receive-side self-test that reuses the sync generator.
package vga_timing_pkg;

  localparam int COL_W = 12;
  localparam int ROW_W = 11;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int BAR_LEN = 16;

  function automatic int line_total(int vis, int front, int sync, int back);
    return vis + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = line_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = line_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_SOLID   = 2'd2,
    MODE_MOVING  = 2'd3
  } mode_e;

  // Combinational decode of the current counter position.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic visible;
    logic frame_first;
    logic line_last;
    logic frame_last;
  } sync_t;

endpackage

// File: rtl/vga_sync_gen.sv
// Column/line counters plus sync, visible and frame-boundary decode. The
// decode describes the current counter state; callers register it.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = H_VISIBLE_DEF,
  parameter int   H_FRONT     = H_FRONT_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BACK      = H_BACK_DEF,
  parameter int   V_VISIBLE   = V_VISIBLE_DEF,
  parameter int   V_FRONT     = V_FRONT_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BACK      = V_BACK_DEF,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output sync_t            tm
);

  localparam int H_TOTAL = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [COL_W-1:0] H_LAST = COL_W'(H_TOTAL - 1);
  localparam logic [COL_W-1:0] H_VIS  = COL_W'(H_VISIBLE);
  localparam logic [COL_W-1:0] HS_BEG = COL_W'(H_VISIBLE + H_FRONT);
  localparam logic [COL_W-1:0] HS_END = COL_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [ROW_W-1:0] V_LAST = ROW_W'(V_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_VIS  = ROW_W'(V_VISIBLE);
  localparam logic [ROW_W-1:0] VS_BEG = ROW_W'(V_VISIBLE + V_FRONT);
  localparam logic [ROW_W-1:0] VS_END = ROW_W'(V_VISIBLE + V_FRONT + V_SYNC);

  always_ff @(posedge clock) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (col == H_LAST) begin
      col <= '0;
      row <= (row == V_LAST) ? '0 : row + 1'b1;
    end else begin
      col <= col + 1'b1;
    end
  end

  always_comb begin
    tm             = '0;
    tm.hsync       = (col >= HS_BEG && col < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    tm.vsync       = (row >= VS_BEG && row < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    tm.visible     = (col < H_VIS) && (row < V_VIS);
    tm.frame_first = (col == '0) && (row == '0);
    tm.line_last   = (col == H_LAST);
    tm.frame_last  = (col == H_LAST) && (row == V_LAST);
  end

endmodule

// File: rtl/vga_pattern_source.sv
// VGA transmit-side test pattern source: sync timing plus a 1-bit-per-channel
// RGB pattern whose mode and colour only change at frame boundaries.
module vga_pattern_source
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = H_VISIBLE_DEF,
  parameter int   H_FRONT     = H_FRONT_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BACK      = H_BACK_DEF,
  parameter int   V_VISIBLE   = V_VISIBLE_DEF,
  parameter int   V_FRONT     = V_FRONT_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BACK      = V_BACK_DEF,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   BAR_WIDTH   = 80,
  parameter int   MOVE_STEP   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [2:0]       solid_rgb,
  output logic             hsync,
  output logic             vsync,
  output logic [2:0]       rgb,
  output logic             visible,
  output logic [COL_W-1:0] display_col,
  output logic [ROW_W-1:0] display_row,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam logic [COL_W-1:0] BAR_LAST = COL_W'(BAR_WIDTH - 1);
  localparam logic [COL_W:0]   H_VIS_X  = (COL_W+1)'(H_VISIBLE);
  localparam logic [COL_W:0]   STEP_X   = (COL_W+1)'(MOVE_STEP);
  localparam logic [COL_W:0]   BLEN_X   = (COL_W+1)'(BAR_LEN - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  sync_t            tm;

  vga_sync_gen #(
    .H_VISIBLE  (H_VISIBLE),
    .H_FRONT    (H_FRONT),
    .H_SYNC     (H_SYNC),
    .H_BACK     (H_BACK),
    .V_VISIBLE  (V_VISIBLE),
    .V_FRONT    (V_FRONT),
    .V_SYNC     (V_SYNC),
    .V_BACK     (V_BACK),
    .SYNC_ACTIVE(SYNC_ACTIVE)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .col  (col),
    .row  (row),
    .tm   (tm)
  );

  mode_e            active_mode;
  logic [2:0]       active_solid;
  logic [COL_W-1:0] bar_pos;
  logic [COL_W-1:0] bar_cnt;
  logic [2:0]       bar_idx;
  logic [COL_W:0]   bar_sum;
  logic [COL_W:0]   bar_end;
  logic             in_bar;
  logic [2:0]       pix_rgb;

  assign bar_sum = {1'b0, bar_pos} + STEP_X;
  assign bar_end = {1'b0, bar_pos} + BLEN_X;
  // Columns past the visible edge are blanked, which clips the bar there.
  assign in_bar  = (col >= bar_pos) && ({1'b0, col} <= bar_end);

  always_ff @(posedge clock) begin
    if (reset) begin
      active_mode  <= mode_e'(mode);
      active_solid <= solid_rgb;
      frame_count  <= '0;
      bar_pos      <= '0;
      bar_cnt      <= '0;
      bar_idx      <= '0;
    end else begin
      if (tm.frame_last) begin
        active_mode  <= mode_e'(mode);
        active_solid <= solid_rgb;
        frame_count  <= frame_count + 8'd1;
        bar_pos      <= (bar_sum >= H_VIS_X) ? '0 : bar_sum[COL_W-1:0];
      end
      // bar_idx tracks the counter column: it names the colour bar of col.
      if (tm.line_last) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pix_rgb = '0;
    if (tm.visible) begin
      case (active_mode)
        MODE_BARS:    pix_rgb = bar_idx;
        MODE_CHECKER: pix_rgb = {3{col[5] ^ row[5]}};
        MODE_SOLID:   pix_rgb = active_solid;
        MODE_MOVING:  pix_rgb = in_bar ? 3'b111 : 3'b000;
        default:      pix_rgb = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      rgb         <= '0;
      visible     <= 1'b0;
      display_col <= '0;
      display_row <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= tm.hsync;
      vsync       <= tm.vsync;
      rgb         <= pix_rgb;
      visible     <= tm.visible;
      display_col <= col;
      display_row <= row;
      frame_start <= tm.frame_first;
    end
  end

endmodule

// File: tb/tb_vga_pattern_source.sv
// Directed bench for vga_pattern_source on a reduced raster (80x47 total,
// 64x40 visible) so several frames, mode changes and bar wrap fit in the run.
module tb_vga_pattern_source;

  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 40, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [2:0]  solid_rgb;
  logic        hsync, vsync, visible, frame_start;
  logic [2:0]  rgb;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;

  vga_pattern_source #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0), .BAR_WIDTH(8), .MOVE_STEP(12)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .visible(visible),
    .display_col(display_col), .display_row(display_row),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         f;
    int         r;
    int         c;
    logic [2:0] rgb;
    string      name;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add(input int f, input int r, input int c, input logic [2:0] e, input string n);
    vec_t v;
    v.f = f; v.r = r; v.c = c; v.rgb = e; v.name = n;
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 32'({hsync, vsync, visible, frame_start, rgb}), 32'b1100_000);
    chk({tag, "_col"}, 32'(display_col), 32'd0);
    chk({tag, "_row"}, 32'(display_row), 32'd0);
    chk({tag, "_fc"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    int vp, fs_seen, last_fs, exp_c, exp_r;
    int tm_err, seq_err, sol_err, sol_n;
    int c, r, f;
    bit vis, found;

    // Frame 0 bars, 1 checker, 2-3 solid, 4.. moving (bar_pos 48, 60, 0).
    add(0, 0, 0, 3'd0, "bars_c0");
    add(0, 2, 7, 3'd0, "bars_c7");
    add(0, 2, 8, 3'd1, "bars_c8");
    add(0, 2, 15, 3'd1, "bars_c15");
    add(0, 2, 16, 3'd2, "bars_c16");
    add(0, 3, 56, 3'd7, "bars_c56");
    add(0, 3, 63, 3'd7, "bars_c63");
    add(0, 3, 64, 3'd0, "bars_c64_blank");
    add(0, 39, 63, 3'd7, "bars_last_line");
    add(0, 40, 5, 3'd0, "bars_row40_blank");
    add(1, 0, 0, 3'd0, "chk_0_0");
    add(1, 0, 32, 3'd7, "chk_32_0");
    add(1, 32, 0, 3'd7, "chk_0_32");
    add(1, 32, 32, 3'd0, "chk_32_32");
    add(2, 0, 0, 3'd5, "solid_first");
    add(2, 39, 63, 3'd5, "solid_kept_after_change");
    add(3, 0, 0, 3'd2, "solid_next_frame");
    add(3, 20, 40, 3'd2, "solid_next_mid");
    add(3, 40, 0, 3'd0, "solid_blank");
    add(4, 0, 47, 3'd0, "mov48_c47");
    add(4, 0, 48, 3'd7, "mov48_c48");
    add(4, 0, 63, 3'd7, "mov48_c63");
    add(4, 5, 64, 3'd0, "mov48_c64");
    add(5, 0, 0, 3'd0, "mov60_no_wrap");
    add(5, 0, 59, 3'd0, "mov60_c59");
    add(5, 0, 60, 3'd7, "mov60_c60");
    add(5, 0, 63, 3'd7, "mov60_c63");
    add(6, 0, 0, 3'd7, "mov0_c0");
    add(6, 0, 15, 3'd7, "mov0_c15");
    add(6, 0, 16, 3'd0, "mov0_c16");
    add(6, 0, 63, 3'd0, "mov0_c63");

    reset = 1'b1; mode = 2'd0; solid_rgb = 3'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("por");
    reset = 1'b0;
    step();
    chk("release_fs", 32'(frame_start), 32'd1);
    chk("release_vis", 32'(visible), 32'd1);

    vp = 0; fs_seen = 0; last_fs = 0; exp_c = 0; exp_r = 0;
    tm_err = 0; seq_err = 0; sol_err = 0; sol_n = 0;
    for (int cyc = 0; cyc < 7 * FRAME + 200 && vp < vt.size(); cyc++) begin
      c = int'(display_col); r = int'(display_row); f = int'(frame_count);
      vis = (c < HV) && (r < VV);
      if (frame_start) begin
        chk("fc_at_frame_start", 32'(frame_count), 32'(fs_seen));
        if (fs_seen > 0) chk("frame_period", 32'(cyc - last_fs), 32'(FRAME));
        last_fs = cyc;
        fs_seen++;
      end
      if (c != exp_c || r != exp_r) seq_err++;
      exp_c = (exp_c == HT - 1) ? 0 : exp_c + 1;
      if (exp_c == 0) exp_r = (exp_r == VT - 1) ? 0 : exp_r + 1;
      if (f < 2) begin
        if (hsync !== ((c >= HV + HF && c < HV + HF + HS) ? 1'b0 : 1'b1)) tm_err++;
        if (vsync !== ((r >= VV + VF && r < VV + VF + VS) ? 1'b0 : 1'b1)) tm_err++;
        if (visible !== vis) tm_err++;
        if (!vis && rgb !== 3'd0) tm_err++;
      end
      if (f == 2) begin
        sol_n++;
        if (rgb !== (vis ? 3'd5 : 3'd0)) sol_err++;
      end
      if (c == 0 && r == 1 && f == 0) mode = 2'd1;
      if (c == 0 && r == 1 && f == 1) begin mode = 2'd2; solid_rgb = 3'd5; end
      if (c == 0 && r == 10 && f == 2) solid_rgb = 3'd2;
      if (c == 0 && r == 1 && f == 3) mode = 2'd3;
      if (vp < vt.size() && f == vt[vp].f && r == vt[vp].r && c == vt[vp].c) begin
        chk(vt[vp].name, 32'(rgb), 32'(vt[vp].rgb));
        vp++;
      end
      step();
    end
    chk("vectors_reached", 32'(vp), 32'(vt.size()));
    chk("sync_visible_frames01", 32'(tm_err), 32'd0);
    chk("col_row_sequence", 32'(seq_err), 32'd0);
    chk("solid_frame_errs", 32'(sol_err), 32'd0);
    chk("solid_frame_len", 32'(sol_n), 32'(FRAME));

    // Truncate a frame with reset at line 20, column 30.
    found = 1'b0;
    for (int i = 0; i < FRAME + 10 && !found; i++) begin
      if (display_row == 11'd20 && display_col == 12'd30) found = 1'b1;
      else step();
    end
    chk("reach_mid_frame", 32'(found), 32'd1);
    reset = 1'b1; mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_outputs("midrst");
    end
    reset = 1'b0;
    step();
    chk("midrst_fs", 32'(frame_start), 32'd1);
    chk("midrst_fc", 32'(frame_count), 32'd0);
    chk("midrst_pos", 32'({display_row, display_col}), 32'd0);
    chk("midrst_vis", 32'(visible), 32'd1);
    repeat (8) step();
    chk("midrst_bars_c8", 32'(rgb), 32'd1);
    chk("midrst_fs_drop", 32'(frame_start), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
